// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the registered ALU control decoder: ALUOp, funct, control codes, FSM states.
package alu_ctrl_pkg;

    localparam int unsigned ALUOP_BASE_W = 2;
    localparam int unsigned FUNCT_BASE_W = 6;
    localparam int unsigned CTRL_BASE_W  = 4;

    localparam logic [ALUOP_BASE_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_BASE_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_BASE_W-1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [FUNCT_BASE_W-1:0] FUNCT_SLL   = 6'h00;
    localparam logic [FUNCT_BASE_W-1:0] FUNCT_SRL   = 6'h02;
    localparam logic [FUNCT_BASE_W-1:0] FUNCT_SRA   = 6'h03;
    localparam logic [FUNCT_BASE_W-1:0] FUNCT_MFHI  = 6'h10;
    localparam logic [FUNCT_BASE_W-1:0] FUNCT_MFLO  = 6'h12;
    localparam logic [FUNCT_BASE_W-1:0] FUNCT_MULT  = 6'h18;
    localparam logic [FUNCT_BASE_W-1:0] FUNCT_MULTU = 6'h19;
    localparam logic [FUNCT_BASE_W-1:0] FUNCT_DIV   = 6'h1A;
    localparam logic [FUNCT_BASE_W-1:0] FUNCT_DIVU  = 6'h1B;
    localparam logic [FUNCT_BASE_W-1:0] FUNCT_ADD   = 6'h20;
    localparam logic [FUNCT_BASE_W-1:0] FUNCT_ADDU  = 6'h21;
    localparam logic [FUNCT_BASE_W-1:0] FUNCT_SUB   = 6'h22;
    localparam logic [FUNCT_BASE_W-1:0] FUNCT_SUBU  = 6'h23;
    localparam logic [FUNCT_BASE_W-1:0] FUNCT_AND   = 6'h24;
    localparam logic [FUNCT_BASE_W-1:0] FUNCT_OR    = 6'h25;
    localparam logic [FUNCT_BASE_W-1:0] FUNCT_XOR   = 6'h26;
    localparam logic [FUNCT_BASE_W-1:0] FUNCT_NOR   = 6'h27;
    localparam logic [FUNCT_BASE_W-1:0] FUNCT_SLT   = 6'h2A;
    localparam logic [FUNCT_BASE_W-1:0] FUNCT_SLTU  = 6'h2B;

    localparam logic [CTRL_BASE_W-1:0] CTRL_AND     = 4'h0;
    localparam logic [CTRL_BASE_W-1:0] CTRL_OR      = 4'h1;
    localparam logic [CTRL_BASE_W-1:0] CTRL_ADD     = 4'h2;
    localparam logic [CTRL_BASE_W-1:0] CTRL_XOR     = 4'h3;
    localparam logic [CTRL_BASE_W-1:0] CTRL_MFHI    = 4'h4;
    localparam logic [CTRL_BASE_W-1:0] CTRL_MFLO    = 4'h5;
    localparam logic [CTRL_BASE_W-1:0] CTRL_SUB     = 4'h6;
    localparam logic [CTRL_BASE_W-1:0] CTRL_SLT     = 4'h7;
    localparam logic [CTRL_BASE_W-1:0] CTRL_SLL     = 4'h8;
    localparam logic [CTRL_BASE_W-1:0] CTRL_SRL     = 4'h9;
    localparam logic [CTRL_BASE_W-1:0] CTRL_SRA     = 4'hA;
    localparam logic [CTRL_BASE_W-1:0] CTRL_SLTU    = 4'hB;
    localparam logic [CTRL_BASE_W-1:0] CTRL_NOR     = 4'hC;
    localparam logic [CTRL_BASE_W-1:0] CTRL_MUL     = 4'hD;
    localparam logic [CTRL_BASE_W-1:0] CTRL_DIV     = 4'hE;
    localparam logic [CTRL_BASE_W-1:0] CTRL_ILLEGAL = 4'hF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational ALUOp/funct decode into a 4-bit ALU control code plus multi-cycle op flags.
module alu_funct_decode
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W = 2,
    parameter int unsigned FUNCT_W = 6
) (
    input  logic [ALUOP_W-1:0]     alu_op,
    input  logic [FUNCT_W-1:0]     funct,
    output logic [CTRL_BASE_W-1:0] control,
    output logic                   illegal,
    output logic                   is_mul,
    output logic                   is_div
);

    logic                    op_hi_zero;
    logic                    funct_hi_zero;
    logic [ALUOP_BASE_W-1:0] op_lo;
    logic [FUNCT_BASE_W-1:0] funct_lo;
    logic [CTRL_BASE_W-1:0]  code;

    // Bits above the architected field widths must be zero for a legal request.
    assign op_hi_zero    = ((alu_op >> ALUOP_BASE_W) == '0);
    assign funct_hi_zero = ((funct >> FUNCT_BASE_W) == '0);
    assign op_lo         = ALUOP_BASE_W'(alu_op);
    assign funct_lo      = FUNCT_BASE_W'(funct);

    always_comb begin
        code = CTRL_ILLEGAL;
        if (op_hi_zero) begin
            case (op_lo)
                ALUOP_ADD: code = CTRL_ADD;
                ALUOP_SUB: code = CTRL_SUB;
                ALUOP_RTYPE: begin
                    if (funct_hi_zero) begin
                        case (funct_lo)
                            FUNCT_ADD,  FUNCT_ADDU:  code = CTRL_ADD;
                            FUNCT_SUB,  FUNCT_SUBU:  code = CTRL_SUB;
                            FUNCT_AND:               code = CTRL_AND;
                            FUNCT_OR:                code = CTRL_OR;
                            FUNCT_XOR:               code = CTRL_XOR;
                            FUNCT_NOR:               code = CTRL_NOR;
                            FUNCT_SLT:               code = CTRL_SLT;
                            FUNCT_SLTU:              code = CTRL_SLTU;
                            FUNCT_SLL:               code = CTRL_SLL;
                            FUNCT_SRL:               code = CTRL_SRL;
                            FUNCT_SRA:               code = CTRL_SRA;
                            FUNCT_MFHI:              code = CTRL_MFHI;
                            FUNCT_MFLO:              code = CTRL_MFLO;
                            FUNCT_MULT, FUNCT_MULTU: code = CTRL_MUL;
                            FUNCT_DIV,  FUNCT_DIVU:  code = CTRL_DIV;
                            default:                 code = CTRL_ILLEGAL;
                        endcase
                    end
                end
                default: code = CTRL_ILLEGAL;
            endcase
        end
    end

    // The illegal code is never produced by a legal decode, so it doubles as the flag.
    assign control = code;
    assign illegal = (code == CTRL_ILLEGAL);
    assign is_mul  = (code == CTRL_MUL);
    assign is_div  = (code == CTRL_DIV);

endmodule

// File: rtl/alu_control_seq.sv
// Registered ALU control decoder with valid/ready issue and MULT/DIV busy sequencing.
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W    = 2,
    parameter int unsigned FUNCT_W    = 6,
    parameter int unsigned CTRL_W     = 4,
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ALUOP_W-1:0] alu_op,
    input  logic [FUNCT_W-1:0] funct,
    output logic               out_valid,
    output logic [CTRL_W-1:0]  control,
    output logic               illegal,
    output logic               busy,
    output logic               hilo_we
);

    localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   out_valid_q, out_valid_d;
    logic [CTRL_W-1:0]      control_q, control_d;
    logic                   illegal_q, illegal_d;
    logic                   hilo_we_q, hilo_we_d;

    logic [CTRL_BASE_W-1:0] dec_control;
    logic                   dec_illegal;
    logic                   dec_is_mul;
    logic                   dec_is_div;
    logic                   accept;

    alu_funct_decode #(
        .ALUOP_W (ALUOP_W),
        .FUNCT_W (FUNCT_W)
    ) u_decode (
        .alu_op  (alu_op),
        .funct   (funct),
        .control (dec_control),
        .illegal (dec_illegal),
        .is_mul  (dec_is_mul),
        .is_div  (dec_is_div)
    );

    assign in_ready = (state_q == ST_IDLE);
    assign accept   = in_valid & in_ready & ~flush;

    // Next-state, counter and output register update.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        hilo_we_d   = 1'b0;
        control_d   = control_q;
        illegal_d   = illegal_q;

        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        out_valid_d = 1'b1;
                        control_d   = CTRL_W'(dec_control);
                        illegal_d   = dec_illegal;
                        if (dec_is_mul) begin
                            state_d = ST_BUSY;
                            cnt_d   = CNT_W'(MUL_CYCLES - 1);
                        end else if (dec_is_div) begin
                            state_d = ST_BUSY;
                            cnt_d   = CNT_W'(DIV_CYCLES - 1);
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == '0) begin
                        state_d   = ST_IDLE;
                        hilo_we_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            control_q   <= '0;
            illegal_q   <= 1'b0;
            hilo_we_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            control_q   <= control_d;
            illegal_q   <= illegal_d;
            hilo_we_q   <= hilo_we_d;
        end
    end

    assign out_valid = out_valid_q;
    assign control   = control_q;
    assign illegal   = illegal_q;
    assign busy      = (state_q == ST_BUSY);
    assign hilo_we   = hilo_we_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed self-checking bench for alu_control_seq with hand-computed expectations.
module tb_alu_control_seq;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] alu_op;
    logic [5:0] funct;
    logic       out_valid;
    logic [3:0] control;
    logic       illegal;
    logic       busy;
    logic       hilo_we;

    int unsigned n_total;
    int unsigned n_bad;

    alu_control_seq dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct     (funct),
        .out_valid (out_valid),
        .control   (control),
        .illegal   (illegal),
        .busy      (busy),
        .hilo_we   (hilo_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs change on the falling edge, outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [5:0] sweep_f [13];
        logic [3:0] sweep_c [13];
        sweep_f = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                    6'h00, 6'h02, 6'h03, 6'h10, 6'h12};
        sweep_c = '{4'h2, 4'h6, 4'h0, 4'h1, 4'h3, 4'hC, 4'h7, 4'hB,
                    4'h8, 4'h9, 4'hA, 4'h4, 4'h5};
        n_total  = 0;
        n_bad    = 0;
        rst      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        alu_op   = 2'b00;
        funct    = 6'h00;

        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_control", 32'(control), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hilo_we", 32'(hilo_we), 32'd0);
        rst = 1'b1;
        step();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);

        // ALUOp 00 adds regardless of funct
        alu_op = 2'b00; funct = 6'h06; in_valid = 1'b1;
        step();
        chk("add_out_valid", 32'(out_valid), 32'd1);
        chk("add_control", 32'(control), 32'h2);
        chk("add_illegal", 32'(illegal), 32'd0);

        alu_op = 2'b01; funct = 6'h3F;
        step();
        chk("sub_control", 32'(control), 32'h6);

        alu_op = 2'b10;
        for (int i = 0; i < 13; i++) begin
            funct = sweep_f[i];
            step();
            chk($sformatf("sweep_valid_%0h", sweep_f[i]), 32'(out_valid), 32'd1);
            chk($sformatf("sweep_ctrl_%0h", sweep_f[i]), 32'(control), 32'(sweep_c[i]));
        end
        in_valid = 1'b0;
        step();
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_control_hold", 32'(control), 32'h5);

        // MULT: four busy cycles, then the HI/LO strobe; a held request waits
        alu_op = 2'b10; funct = 6'h18; in_valid = 1'b1;
        step();
        chk("mul_control", 32'(control), 32'hD);
        chk("mul_busy_1", 32'(busy), 32'd1);
        chk("mul_in_ready_1", 32'(in_ready), 32'd0);
        alu_op = 2'b00; funct = 6'h00;
        for (int i = 2; i <= 4; i++) begin
            step();
            chk($sformatf("mul_busy_%0d", i), 32'(busy), 32'd1);
            chk($sformatf("mul_in_ready_%0d", i), 32'(in_ready), 32'd0);
            chk($sformatf("mul_hilo_%0d", i), 32'(hilo_we), 32'd0);
            chk($sformatf("mul_out_valid_%0d", i), 32'(out_valid), 32'd0);
        end
        step();
        chk("mul_done_hilo", 32'(hilo_we), 32'd1);
        chk("mul_done_busy", 32'(busy), 32'd0);
        chk("mul_done_out_valid", 32'(out_valid), 32'd0);
        step();
        chk("mul_next_out_valid", 32'(out_valid), 32'd1);
        chk("mul_next_control", 32'(control), 32'h2);
        chk("mul_next_hilo", 32'(hilo_we), 32'd0);

        // Illegal funct and reserved ALUOp
        alu_op = 2'b10; funct = 6'h01;
        step();
        chk("ill_funct_control", 32'(control), 32'hF);
        chk("ill_funct_flag", 32'(illegal), 32'd1);
        chk("ill_funct_busy", 32'(busy), 32'd0);
        alu_op = 2'b11; funct = 6'h18;
        step();
        chk("ill_op_control", 32'(control), 32'hF);
        chk("ill_op_flag", 32'(illegal), 32'd1);
        chk("ill_op_busy", 32'(busy), 32'd0);
        in_valid = 1'b0;
        step();

        // DIV aborted by flush in its third cycle
        alu_op = 2'b10; funct = 6'h1A; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("div_control", 32'(control), 32'hE);
        chk("div_illegal", 32'(illegal), 32'd0);
        chk("div_busy", 32'(busy), 32'd1);
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("div_flush_busy", 32'(busy), 32'd0);
        chk("div_flush_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("div_flush_hilo_%0d", i), 32'(hilo_we), 32'd0);
            step();
        end

        // Flush suppresses a same-cycle accept
        alu_op = 2'b00; in_valid = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_accept_out_valid", 32'(out_valid), 32'd0);
        chk("flush_accept_busy", 32'(busy), 32'd0);

        // Flush coinciding with the completion edge drops the strobe
        alu_op = 2'b10; funct = 6'h19; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        chk("mulu_last_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_done_hilo", 32'(hilo_we), 32'd0);
        chk("flush_done_busy", 32'(busy), 32'd0);
        step();
        chk("flush_done_hilo_late", 32'(hilo_we), 32'd0);

        // Asynchronous reset in the middle of a DIVU
        alu_op = 2'b10; funct = 6'h1B; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("divu_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_control", 32'(control), 32'd0);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        step();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("rst_mid_hilo_%0d", i), 32'(hilo_we), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
